// File: rtl/jk_pkg.sv
// Shared types and next-state helper for the JK register bank.
package jk_pkg;

    // Per-bit JK operation, encoded as {j,k}
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_t;

    // Next state of a single JK bit given its current value and operation
    function automatic logic jk_next(input logic q, input jk_op_t op);
        logic nxt;
        case (op)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK bit: next-state selection (rst > load > en > hold) and its flop.
// q_nxt exposes the value the flop will take on the next non-reset edge.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic d,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_nxt
);

    logic   q_r;
    logic   q_nxt_s;
    jk_op_t op_s;

    assign op_s = jk_op_t'({j, k});

    // Select the next bit value: load wins over the JK update, otherwise hold
    always_comb begin
        q_nxt_s = q_r;
        if (load) begin
            q_nxt_s = d;
        end else if (en) begin
            q_nxt_s = jk_next(q_r, op_s);
        end else begin
            q_nxt_s = q_r;
        end
    end

    // State flop with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= q_nxt_s;
        end
    end

    assign q     = q_r;
    assign q_nxt = q_nxt_s;

endmodule

// File: rtl/jk_reg_bank.sv
// Parametrised bank of JK flip-flops with parallel load, a registered
// "any bit changed" flag and an optional saturating toggle-event counter.
// Optional feature macro: JKREG_TOGGLE_CNT_EN (counter present when defined,
// toggle_cnt tied to zero otherwise).
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_n,
    output logic             changed,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] out_s;
    logic [WIDTH-1:0] out_nxt_s;
    logic             changed_r;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RST_VAL (RESET_VAL[gi])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .en    (en),
            .d     (d[gi]),
            .j     (j[gi]),
            .k     (k[gi]),
            .q     (out_s[gi]),
            .q_nxt (out_nxt_s[gi])
        );
    end

    // Flag any edge whose update alters the stored value; reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_r <= 1'b0;
        end else begin
            changed_r <= (out_nxt_s != out_s);
        end
    end

`ifdef JKREG_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             tgl_evt_s;

    // One event per cycle with at least one toggling bit, regardless of count
    assign tgl_evt_s = ~load & en & (|(j & k));

    // Saturating event counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tgl_evt_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign toggle_cnt = cnt_r;
`else
    assign toggle_cnt = {CNT_W{1'b0}};
`endif

    assign out     = out_s;
    assign out_n   = ~out_s;
    assign changed = changed_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=8, RESET_VAL=8'hA5, CNT_W=2).
// The driver applies one vector per cycle on the falling edge and queues the
// hand-computed post-edge state; the monitor pops and compares just after
// each rising edge.
module tb_jk_reg_bank;

`ifdef JKREG_TOGGLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] d;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] out;
    logic [7:0] out_n;
    logic       changed;
    logic [1:0] toggle_cnt;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic       chg;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    jk_reg_bank #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5),
        .CNT_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .d          (d),
        .j          (j),
        .k          (k),
        .out        (out),
        .out_n      (out_n),
        .changed    (changed),
        .toggle_cnt (toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector and queue the expected state after the next rising edge.
    // cnt_m is the counter value when the counter is built in.
    task automatic drive(input string nm, input logic r, input logic ld, input logic e,
                         input logic [7:0] dd, input logic [7:0] jj, input logic [7:0] kk,
                         input logic [7:0] eo, input logic ec, input logic [1:0] cnt_m);
        exp_t x;
        @(negedge clk);
        rst  = r;
        load = ld;
        en   = e;
        d    = dd;
        j    = jj;
        k    = kk;
        x.name = nm;
        x.out  = eo;
        x.chg  = ec;
        x.cnt  = CNT_ON ? cnt_m : 2'd0;
        sb_q.push_back(x);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                checks = checks + 4;
                if (out !== x.out) begin
                    errors++;
                    $display("FAIL %s.out actual=%h expected=%h", x.name, out, x.out);
                end
                if (out_n !== ~x.out) begin
                    errors++;
                    $display("FAIL %s.out_n actual=%h expected=%h", x.name, out_n, ~x.out);
                end
                if (changed !== x.chg) begin
                    errors++;
                    $display("FAIL %s.changed actual=%b expected=%b", x.name, changed, x.chg);
                end
                if (toggle_cnt !== x.cnt) begin
                    errors++;
                    $display("FAIL %s.toggle_cnt actual=%0d expected=%0d", x.name, toggle_cnt, x.cnt);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
        d    = 8'h00;
        j    = 8'h00;
        k    = 8'h00;

        // Reset overrides load/en/jk
        drive("rst0", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 1'b0, 2'd0);
        drive("rst1", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 1'b0, 2'd0);
        // Load 0F (A5 -> 0F changes)
        drive("ld0f", 1'b0, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h0F, 1'b1, 2'd0);
        // Truth table from 0F: j=CA k=A6 -> T,S,C,H,S,C,T,H -> 1100_1001
        drive("truth", 1'b0, 1'b0, 1'b1, 8'h00, 8'hCA, 8'hA6, 8'hC9, 1'b1, 2'd1);
        // Load beats en and j/k
        drive("ld3c", 1'b0, 1'b1, 1'b1, 8'h3C, 8'hFF, 8'hFF, 8'h3C, 1'b1, 2'd1);
        // en=0 holds and ignores j/k
        for (int i = 0; i < 3; i++)
            drive("hold", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h3C, 1'b0, 2'd1);
        // Load of identical value
        drive("ldsame", 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h3C, 1'b0, 2'd1);
        drive("ld00", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd1);
        // Toggle divider on bit 0
        drive("div1", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1, 2'd2);
        drive("div2", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1, 2'd3);
        drive("div3", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1, 2'd3);
        drive("div4", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1, 2'd3);
        drive("div5", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1, 2'd3);
        drive("div6", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1, 2'd3);
        // Mid-operation reset discards pending load
        drive("rst2", 1'b1, 1'b1, 1'b1, 8'h77, 8'hFF, 8'hFF, 8'hA5, 1'b0, 2'd0);
        // Set without toggle: no count, bit0 already 1 so no change
        drive("setnc", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'hA5, 1'b0, 2'd0);
        // Counter: five full-toggle cycles saturate at 3
        drive("cnt1", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h5A, 1'b1, 2'd1);
        drive("cnt2", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hA5, 1'b1, 2'd2);
        drive("cnt3", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h5A, 1'b1, 2'd3);
        drive("cnt4", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hA5, 1'b1, 2'd3);
        drive("cnt5", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h5A, 1'b1, 2'd3);
        // Load does not clear the counter; en=0 does not count
        drive("ld11", 1'b0, 1'b1, 1'b1, 8'h11, 8'hFF, 8'hFF, 8'h11, 1'b1, 2'd3);
        drive("enoff", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h11, 1'b0, 2'd3);
        drive("rst3", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b0, 2'd0);

        // Drain the scoreboard within a bounded number of cycles
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
